// File: rtl/freq_counter_bcd.sv
// freq_counter_bcd: gated BCD frequency counter for the seven-segment display
// Counts synchronized rising edges of fxin_i over GATE_CYCLES clocks and
// latches the count as packed BCD at the end of each back-to-back window.
// Ports:
//   clk_i       system clock
//   rst_n_i     synchronous active-low reset
//   en_i        measurement enable; low holds the block idle
//   fxin_i      asynchronous signal under test
//   bcd_o       latched count, digit 0 (units) in bits [3:0]
//   valid_o     one-cycle pulse when bcd_o / overflow_o update
//   overflow_o  last window exceeded 10^DIGITS-1 edges
module freq_counter_bcd #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int DIGITS      = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                fxin_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                valid_o,
    output logic                overflow_o
);
    localparam int W  = 4 * DIGITS;
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic {IDLE, MEAS} state_e;

    state_e        state_q, state_d;
    logic          s1_q, s2_q, sp_q, rise;
    logic [GW-1:0] gate_q, gate_d;
    logic [W-1:0]  acc_q, acc_d, acc_inc, bcd_q, bcd_d;
    logic          ov_q, ov_d, valid_q, valid_d, overflow_q, overflow_d;
    logic          all_nines;

    assign rise       = s2_q & ~sp_q;
    assign bcd_o      = bcd_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;

    // Decimal ripple increment; all_nines doubles as the carry chain and
    // ends up set only when every digit is 9.
    always_comb begin
        acc_inc   = acc_q;
        all_nines = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            acc_inc[4*d +: 4] = all_nines ? ((acc_q[4*d +: 4] == 4'd9) ? 4'd0 : acc_q[4*d +: 4] + 4'd1)
                                          : acc_q[4*d +: 4];
            all_nines = all_nines & (acc_q[4*d +: 4] == 4'd9);
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        acc_d      = acc_q;
        ov_d       = ov_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (state_q == IDLE || !en_i) begin
            // idle, or enable dropped: discard the partial window
            state_d = en_i ? MEAS : IDLE;
            gate_d  = '0;
            acc_d   = '0;
            ov_d    = 1'b0;
        end else if (gate_q == LAST) begin
            // an edge on the last cycle belongs to the next window
            bcd_d      = acc_q;
            overflow_d = ov_q;
            valid_d    = 1'b1;
            gate_d     = '0;
            acc_d      = W'(rise);
            ov_d       = 1'b0;
        end else begin
            gate_d = gate_q + GW'(1);
            if (rise) begin
                acc_d = all_nines ? acc_q : acc_inc;
                ov_d  = ov_q | all_nines;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            sp_q       <= 1'b0;
            gate_q     <= '0;
            acc_q      <= '0;
            ov_q       <= 1'b0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= fxin_i;
            s2_q       <= s1_q;
            sp_q       <= s2_q;
            gate_q     <= gate_d;
            acc_q      <= acc_d;
            ov_q       <= ov_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_freq_counter_bcd.sv
// tb_freq_counter_bcd: directed self-checking bench for freq_counter_bcd
module tb_freq_counter_bcd;
    logic        clk = 1'b0;
    logic        rst_n, en_a, en_b, en_c, fxin, lvl;
    logic [31:0] bcd_a, bcd_c;
    logic [7:0]  bcd_b;
    logic        valid_a, valid_b, valid_c, ovf_a, ovf_b, ovf_c;
    int          per, left, ph;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    freq_counter_bcd #(.GATE_CYCLES(1000), .DIGITS(8)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en_a), .fxin_i(fxin),
        .bcd_o(bcd_a), .valid_o(valid_a), .overflow_o(ovf_a));

    freq_counter_bcd #(.GATE_CYCLES(1000), .DIGITS(2)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en_b), .fxin_i(fxin),
        .bcd_o(bcd_b), .valid_o(valid_b), .overflow_o(ovf_b));

    freq_counter_bcd #(.GATE_CYCLES(10000), .DIGITS(8)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en_c), .fxin_i(fxin),
        .bcd_o(bcd_c), .valid_o(valid_c), .overflow_o(ovf_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // per = 0 or left = 0 holds fxin at lvl; otherwise pulses of period per
    // (high for per/2), left pulses remaining or -1 for an endless stream
    task automatic set_pat(input int p, input logic l, input int n);
        per  = p;
        lvl  = l;
        left = n;
        ph   = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (per == 0 || left == 0) fxin = lvl;
        else begin
            fxin = (ph < per / 2);
            ph++;
            if (ph == per) begin
                ph = 0;
                if (left > 0) left--;
            end
        end
    endtask

    function automatic logic vsel(input int w);
        return (w == 0) ? valid_a : (w == 1) ? valid_b : valid_c;
    endfunction

    task automatic wait_valid(input int w, input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!vsel(w) && n < lim);
    endtask

    initial begin
        int n, vc;
        rst_n = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;
        fxin = 1'b0;
        set_pat(0, 1'b0, 0);
        repeat (3) tick();
        check("rst_bcd", bcd_a, 32'h0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        rst_n = 1'b1;
        set_pat(10, 1'b0, -1);
        repeat (30) tick();
        en_a = 1'b1;
        wait_valid(0, 1100, n);
        check("rate_first_gap", n, 1001);
        check("rate_bcd1", bcd_a, 32'h00000100);
        check("rate_ovf1", ovf_a, 1'b0);
        tick();
        check("valid_width", valid_a, 1'b0);
        wait_valid(0, 1100, n);
        check("rate_gap", n, 999);
        check("rate_bcd2", bcd_a, 32'h00000100);
        set_pat(0, 1'b0, 0);
        en_a = 1'b0;
        repeat (5) tick();
        check("idle_hold", bcd_a, 32'h00000100);
        en_a = 1'b1;
        wait_valid(0, 1100, n);
        check("zero_lo_gap", n, 1001);
        check("zero_lo_bcd", bcd_a, 32'h0);
        set_pat(0, 1'b1, 0);
        en_a = 1'b0;
        repeat (5) tick();
        en_a = 1'b1;
        wait_valid(0, 1100, n);
        check("zero_hi_bcd", bcd_a, 32'h0);
        set_pat(10, 1'b0, -1);
        en_a = 1'b0;
        repeat (5) tick();
        en_a = 1'b1;
        wait_valid(0, 1100, n);
        check("rate_again_bcd", bcd_a, 32'h00000100);
        repeat (700) tick();
        en_a = 1'b0;
        vc = 0;
        repeat (50) begin
            tick();
            vc += int'(valid_a);
        end
        check("drop_novalid", vc, 0);
        check("drop_hold", bcd_a, 32'h00000100);
        en_a = 1'b1;
        wait_valid(0, 1100, n);
        check("drop_gap", n, 1001);
        check("drop_bcd", bcd_a, 32'h00000100);
        repeat (490) tick();
        set_pat(0, 1'b0, 0);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_bcd", bcd_a, 32'h0);
        check("midrst_valid", valid_a, 1'b0);
        check("midrst_ovf", ovf_a, 1'b0);
        rst_n = 1'b1;
        set_pat(10, 1'b0, -1);
        wait_valid(0, 1100, n);
        check("midrst_gap", n, 1001);
        check("midrst_bcd2", bcd_a, 32'h00000100);
        en_a = 1'b0;
        set_pat(4, 1'b0, -1);
        repeat (10) tick();
        en_b = 1'b1;
        wait_valid(1, 1100, n);
        check("ovf_gap", n, 1001);
        check("ovf_bcd", bcd_b, 8'h99);
        check("ovf_flag", ovf_b, 1'b1);
        set_pat(20, 1'b0, -1);
        wait_valid(1, 1100, n);
        check("ovf_gap2", n, 1000);
        check("ovf_clear", ovf_b, 1'b0);
        wait_valid(1, 1100, n);
        check("slow_bcd", bcd_b, 8'h50);
        check("slow_ovf", ovf_b, 1'b0);
        en_b = 1'b0;
        set_pat(0, 1'b0, 0);
        repeat (10) tick();
        en_c = 1'b1;
        set_pat(5, 1'b0, 1999);
        wait_valid(2, 12000, n);
        check("carry_gap", n, 10001);
        check("carry_1999", bcd_c, 32'h00001999);
        check("carry_ovf", ovf_c, 1'b0);
        set_pat(4, 1'b0, 2000);
        wait_valid(2, 12000, n);
        check("carry_gap2", n, 10000);
        check("carry_2000", bcd_c, 32'h00002000);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
